rgb_merge: RTL and testbench

RGB_MERGE -- requirements
Module: rgb_merge

---
 rtl/rgb_merge.sv | 139 +++++++++++++
 tb/tb_rgb_merge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_merge.sv
// Merges three independently-timed 8-bit Sobel channels into one packed 24-bit RGB stream.
// Optional end-of-frame marking is compiled in with `define RGB_MERGE_EOF_EN.
module rgb_merge #(
    parameter int FRAME_W = 256,
    parameter int FRAME_H = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_result_r_vld,
    input  logic [7:0]  i_result_r_data,
    output logic        i_result_r_busy,
    input  logic        i_result_g_vld,
    input  logic [7:0]  i_result_g_data,
    output logic        i_result_g_busy,
    input  logic        i_result_b_vld,
    input  logic [7:0]  i_result_b_data,
    output logic        i_result_b_busy,
    output logic        o_pixel_vld,
    output logic [23:0] o_pixel_data,
    input  logic        o_pixel_busy,
    output logic        o_pixel_last
);

    typedef enum logic {ST_EMPTY, ST_FULL} state_t;

    // Channel index 0 = R, 1 = G, 2 = B.
    logic [2:0] w_in_vld;
    logic [7:0] w_in_data [3];
    logic [2:0] w_busy;
    logic [2:0] w_nonempty;
    logic [7:0] w_head [3];
    logic       w_load;
    logic       w_xfer;
    state_t     r_state;
    state_t     w_state_next;
    logic [23:0] r_data;

    assign w_in_vld     = {i_result_b_vld, i_result_g_vld, i_result_r_vld};
    assign w_in_data[0] = i_result_r_data;
    assign w_in_data[1] = i_result_g_data;
    assign w_in_data[2] = i_result_b_data;

    assign i_result_r_busy = w_busy[0];
    assign i_result_g_busy = w_busy[1];
    assign i_result_b_busy = w_busy[2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            logic [7:0] r_mem [2];
            logic       r_wr_ptr;
            logic       r_rd_ptr;
            logic [1:0] r_count;
            logic       w_push;

            // Busy depends only on reset and the stored count, never on any vld or downstream busy.
            assign w_busy[gi]     = i_rst | (r_count == 2'd2);
            assign w_push         = w_in_vld[gi] & ~w_busy[gi];
            assign w_nonempty[gi] = (r_count != 2'd0);
            assign w_head[gi]     = r_mem[r_rd_ptr];

            always_ff @(posedge i_clk) begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= w_in_data[gi];
                end
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                    r_count  <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_wr_ptr <= ~r_wr_ptr;
                    end
                    if (w_load) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    case ({w_push, w_load})
                        2'b10:   r_count <= r_count + 2'd1;
                        2'b01:   r_count <= r_count - 2'd1;
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // A new pixel may enter the output register when it is empty or being emptied this edge.
    assign w_xfer = (r_state == ST_FULL) & ~o_pixel_busy;
    assign w_load = (&w_nonempty) & ((r_state == ST_EMPTY) | ~o_pixel_busy);

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = ST_FULL;
        end else if (w_xfer) begin
            w_state_next = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_EMPTY;
            r_data  <= 24'd0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_data <= {w_head[0], w_head[1], w_head[2]};
            end
        end
    end

    assign o_pixel_vld  = (r_state == ST_FULL);
    assign o_pixel_data = r_data;

`ifdef RGB_MERGE_EOF_EN
    localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
    localparam int CNT_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIXELS - 1);

    // Index of the pixel currently held; advances only when that pixel leaves.
    logic [CNT_W-1:0] r_pix_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pix_cnt <= '0;
        end else if (w_xfer) begin
            r_pix_cnt <= (r_pix_cnt == LAST_IDX) ? '0 : r_pix_cnt + 1'b1;
        end
    end

    assign o_pixel_last = (r_state == ST_FULL) & (r_pix_cnt == LAST_IDX);
`else
    assign o_pixel_last = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_merge.sv
// Directed and randomized checks of the rgb_merge channel alignment, backpressure,
// reset and end-of-frame behaviour; one line per observed transaction.
module tb_rgb_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_vld, g_vld, b_vld;
    logic [7:0]  r_data, g_data, b_data;
    logic        r_busy, g_busy, b_busy;
    logic        px_vld;
    logic [23:0] px_data;
    logic        px_busy;
    logic        px_last;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rgb_merge #(.FRAME_W(4), .FRAME_H(2)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_result_r_vld  (r_vld),
        .i_result_r_data (r_data),
        .i_result_r_busy (r_busy),
        .i_result_g_vld  (g_vld),
        .i_result_g_data (g_data),
        .i_result_g_busy (g_busy),
        .i_result_b_vld  (b_vld),
        .i_result_b_data (b_data),
        .i_result_b_busy (b_busy),
        .o_pixel_vld     (px_vld),
        .o_pixel_data    (px_data),
        .o_pixel_busy    (px_busy),
        .o_pixel_last    (px_last)
    );

    task automatic drive_all(input logic v, input logic [7:0] d);
        r_vld = v; g_vld = v; b_vld = v;
        r_data = d; g_data = d; b_data = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_all(1'b0, 8'h00);
        px_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_all(1'b0, 8'h00);
        px_busy = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (px_vld !== 1'b0 || px_data !== 24'd0 || px_last !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: vld=%b data=%h last=%b required 0/000000/0", px_vld, px_data, px_last);
        end
        n_cmp++;
        if ({r_busy, g_busy, b_busy} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_busy: busy=%b required 111", {r_busy, g_busy, b_busy});
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({r_busy, g_busy, b_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release_busy: busy=%b required 000", {r_busy, g_busy, b_busy});
        end
        $display("reset: checked idle outputs and busy");
    endtask

    task automatic test_aligned();
        logic [7:0] d;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1 || c == 10) begin
                n_cmp++;
                if (px_vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL aligned_vld_c%0d: vld=%b required 0", c, px_vld);
                end
            end else if (c >= 2) begin
                d = 8'(8'h10 + c - 2);
                n_cmp++;
                if (px_vld !== 1'b1 || px_data !== {d, d, d} || {r_busy, g_busy, b_busy} !== 3'b000) begin
                    n_err++;
                    $display("FAIL aligned_pix_c%0d: vld=%b data=%h busy=%b required 1/%h/000",
                             c, px_vld, px_data, {r_busy, g_busy, b_busy}, {d, d, d});
                end else begin
                    $display("aligned: pixel %h", px_data);
                end
            end
            if (c < 8) drive_all(1'b1, 8'(8'h10 + c));
            else drive_all(1'b0, 8'h00);
        end
    endtask

    task automatic test_skew();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                n_cmp++;
                if (r_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL skew_rbusy_c%0d: busy=%b required 0", c, r_busy);
                end
            end
            if (c >= 1 && c != 7) begin
                n_cmp++;
                if (px_vld !== 1'b0) begin
                    n_err++;
                    $display("FAIL skew_vld_c%0d: vld=%b required 0", c, px_vld);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (px_vld !== 1'b1 || px_data !== 24'hAABBCC) begin
                    n_err++;
                    $display("FAIL skew_pix: vld=%b data=%h required 1/aabbcc", px_vld, px_data);
                end else begin
                    $display("skew: pixel %h", px_data);
                end
            end
            drive_all(1'b0, 8'h00);
            if (c == 0) begin r_vld = 1'b1; r_data = 8'hAA; end
            if (c == 3) begin g_vld = 1'b1; g_data = 8'hBB; end
            if (c == 5) begin b_vld = 1'b1; b_data = 8'hCC; end
        end
    endtask

    task automatic test_backpressure();
        int seq = 0;
        px_busy = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                n_cmp++;
                if (px_vld !== 1'b1 || px_data !== 24'h202020) begin
                    n_err++;
                    $display("FAIL bp_hold_c%0d: vld=%b data=%h required 1/202020", c, px_vld, px_data);
                end
            end
            if (c == 2 || c == 3 || c == 9) begin
                n_cmp++;
                if ({r_busy, g_busy, b_busy} !== ((c == 2) ? 3'b000 : 3'b111)) begin
                    n_err++;
                    $display("FAIL bp_busy_c%0d: busy=%b required %b", c, {r_busy, g_busy, b_busy},
                             (c == 2) ? 3'b000 : 3'b111);
                end
            end
            if (c < 10) begin
                if (r_busy === 1'b0) begin
                    drive_all(1'b1, 8'(8'h20 + seq));
                    seq++;
                end else begin
                    drive_all(1'b1, 8'(8'h20 + seq));
                end
            end else begin
                drive_all(1'b0, 8'h00);
                px_busy = 1'b0;
            end
        end
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (k < 3 && (px_vld !== 1'b1 || px_data !== {3{8'(8'h20 + k)}})) begin
                n_err++;
                $display("FAIL bp_release_%0d: vld=%b data=%h required 1/%h", k, px_vld, px_data,
                         {3{8'(8'h20 + k)}});
            end else if (k == 3 && px_vld !== 1'b0) begin
                n_err++;
                $display("FAIL bp_drained: vld=%b required 0", px_vld);
            end else if (k < 3) begin
                $display("backpressure: released pixel %h", px_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        px_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_all(1'b1, 8'(8'h30 + c));
        end
        @(negedge clk);
        n_cmp++;
        if (px_vld !== 1'b1 || px_data !== 24'h303030 || {r_busy, g_busy, b_busy} !== 3'b111) begin
            n_err++;
            $display("FAIL rstmid_pre: vld=%b data=%h busy=%b required 1/303030/111",
                     px_vld, px_data, {r_busy, g_busy, b_busy});
        end
        rst = 1'b1;
        drive_all(1'b1, 8'h55);
        @(negedge clk);
        n_cmp++;
        if (px_vld !== 1'b0 || px_data !== 24'd0) begin
            n_err++;
            $display("FAIL rstmid_out: vld=%b data=%h required 0/000000", px_vld, px_data);
        end
        rst = 1'b0;
        px_busy = 1'b0;
        drive_all(1'b1, 8'h40);
        #1;
        n_cmp++;
        if ({r_busy, g_busy, b_busy} !== 3'b000) begin
            n_err++;
            $display("FAIL rstmid_busy: busy=%b required 000", {r_busy, g_busy, b_busy});
        end
        @(negedge clk);
        drive_all(1'b0, 8'h00);
        n_cmp++;
        if (px_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_lat: vld=%b required 0", px_vld);
        end
        @(negedge clk);
        n_cmp++;
        if (px_vld !== 1'b1 || px_data !== 24'h404040) begin
            n_err++;
            $display("FAIL rstmid_next: vld=%b data=%h required 1/404040", px_vld, px_data);
        end else begin
            $display("reset_mid: post-reset pixel %h", px_data);
        end
        @(negedge clk);
        n_cmp++;
        if (px_vld !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_drain: vld=%b required 0", px_vld);
        end
    endtask

    task automatic test_eof();
        logic       exp_last;
        logic [7:0] d;
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 18) begin
                d = 8'(c - 1);
`ifdef RGB_MERGE_EOF_EN
                exp_last = (c - 1 == 8) || (c - 1 == 16);
`else
                exp_last = 1'b0;
`endif
                n_cmp++;
                if (px_vld !== 1'b1 || px_data !== {d, d, d} || px_last !== exp_last) begin
                    n_err++;
                    $display("FAIL eof_pix%0d: vld=%b data=%h last=%b required 1/%h/%b",
                             c - 1, px_vld, px_data, px_last, {d, d, d}, exp_last);
                end else begin
                    $display("eof: pixel %0d data %h last %b", c - 1, px_data, px_last);
                end
            end
            if (c < 17) drive_all(1'b1, 8'(c + 1));
            else drive_all(1'b0, 8'h00);
        end
        n_cmp++;
        if (px_vld !== 1'b0 || px_last !== 1'b0) begin
            n_err++;
            $display("FAIL eof_idle: vld=%b last=%b required 0/0", px_vld, px_last);
        end
    endtask

    task automatic test_random();
        logic [7:0]  qr[$], qg[$], qb[$];
        logic [23:0] exp;
        int got = 0;
        do_reset();
        for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
            @(negedge clk);
            r_vld = ($urandom_range(0, 3) != 0); r_data = 8'($urandom);
            g_vld = ($urandom_range(0, 3) != 0); g_data = 8'($urandom);
            b_vld = ($urandom_range(0, 3) != 0); b_data = 8'($urandom);
            px_busy = ($urandom_range(0, 2) == 0);
            #1;
            if (r_vld && !r_busy) qr.push_back(r_data);
            if (g_vld && !g_busy) qg.push_back(g_data);
            if (b_vld && !b_busy) qb.push_back(b_data);
            if (px_vld && !px_busy) begin
                n_cmp++;
                got++;
                if (qr.size() == 0 || qg.size() == 0 || qb.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_pix%0d: data=%h required nothing (scoreboard empty)", got, px_data);
                end else begin
                    exp = {qr.pop_front(), qg.pop_front(), qb.pop_front()};
                    if (px_data !== exp) begin
                        n_err++;
                        $display("FAIL rand_pix%0d: data=%h required %h", got, px_data, exp);
                    end else begin
                        $display("random: pixel %0d %h", got, px_data);
                    end
                end
            end
        end
        n_cmp++;
        if (got < 10000) begin
            n_err++;
            $display("FAIL rand_timeout: pixels=%0d required 10000", got);
        end
        @(negedge clk);
        drive_all(1'b0, 8'h00);
        px_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_skew();
        test_backpressure();
        test_reset_mid();
        test_eof();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
